// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals shared by alu_arbiter and its clients
interface alu_arbiter_if #(
  parameter int W = 32,
  parameter int N = 4,
  parameter int IDW = 2
);
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0] alu_op;
  logic [W-1:0] alu_result;
  logic alu_zero;
  logic rsp_valid;
  logic rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0] rsp_result;
  logic rsp_zero;
  logic rsp_err;
  logic busy;
  modport slave (
    input req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );
  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    input req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU among N requesters with a tagged response port
module alu_arbiter #(
  parameter int W = 32,
  parameter int N = 4,
  parameter int IDW = 2
) (
  input logic clk,
  input logic reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [IDW-1:0] ptr, g, lo, hi, id_r, rsp_id;
  logic [W-1:0] a_r, b_r, rsp_result;
  logic [2:0] op_r;
  logic any, hit, legal, rsp_zero, rsp_err;
  always_comb begin
    any = 1'b0;
    hit = 1'b0;
    lo = '0;
    hi = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo = IDW'(i);
        any = 1'b1;
        if (i >= int'(ptr)) begin
          hi = IDW'(i);
          hit = 1'b1;
        end
      end
    end
    g = hit ? hi : lo;
    state_n = state == IDLE ? (any ? EXEC : IDLE) : state == EXEC ? RESP : (bus.rsp_ready ? IDLE : RESP);
  end
  assign legal = op_r inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      a_r <= '0;
      b_r <= '0;
      op_r <= '0;
      id_r <= '0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        a_r <= bus.req_a[g*W +: W];
        b_r <= bus.req_b[g*3*0 + g*W +: W];
        op_r <= bus.req_op[g*3 +: 3];
        id_r <= g;
        ptr <= g == IDW'(N - 1) ? '0 : g + 1'b1;
      end
      if (state == EXEC) begin
        rsp_id <= id_r;
        rsp_result <= legal ? bus.alu_result : '0;
        rsp_zero <= legal ? bus.alu_zero : 1'b1;
        rsp_err <= !legal;
      end
    end
  end
  assign bus.req_ready = (state == IDLE && any && !reset) ? N'(1) << g : '0;
  assign bus.alu_a = a_r;
  assign bus.alu_b = b_r;
  assign bus.alu_op = op_r;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_id = rsp_id;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_zero = rsp_zero;
  assign bus.rsp_err = rsp_err;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, corner sequences and a randomized round-robin model for alu_arbiter
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int IDW = 2;
  typedef struct {
    int id;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic z;
    logic e;
  } vec_t;
  typedef struct {
    int id;
    logic [31:0] r;
    logic z;
    logic e;
    int gcyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [W-1:0] alu_r;
  alu_arbiter_if #(.W(W), .N(N), .IDW(IDW)) bus ();
  alu_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    alu_r = bus.alu_op == 3'b000 ? bus.alu_a & bus.alu_b :
            bus.alu_op == 3'b001 ? bus.alu_a | bus.alu_b :
            bus.alu_op == 3'b010 ? bus.alu_a + bus.alu_b :
            bus.alu_op == 3'b110 ? bus.alu_a - bus.alu_b :
            bus.alu_op == 3'b111 ? {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)} :
            bus.alu_a ^ ~bus.alu_b;
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero = alu_r == '0;
  function automatic logic [33:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic ok;
    ok = op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    r = op == 3'b000 ? a & b : op == 3'b001 ? a | b : op == 3'b010 ? a + b :
        op == 3'b110 ? a - b : op == 3'b111 ? ($signed(a) < $signed(b) ? 32'd1 : 32'd0) : 32'd0;
    return {!ok, r == 32'd0, r};
  endfunction
  function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++)
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ops(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_op[id*3 +: 3] = op;
  endtask
  vec_t vecs[9];
  exp_t q[$];
  exp_t e;
  logic [N-1:0] pend;
  logic [N-1:0] exp_ready;
  logic [33:0] rv;
  int order[6];
  int last, cnt, g, mptr;
  logic [31:0] ra;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{1, 3'b010, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0};
    vecs[1] = '{0, 3'b110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0};
    vecs[2] = '{0, 3'b111, 32'd3, 32'd9, 32'd1, 1'b0, 1'b0};
    vecs[3] = '{0, 3'b000, 32'd12, 32'd10, 32'd8, 1'b0, 1'b0};
    vecs[4] = '{0, 3'b001, 32'd12, 32'd3, 32'd15, 1'b0, 1'b0};
    vecs[5] = '{2, 3'b011, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1};
    vecs[6] = '{3, 3'b110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[7] = '{2, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0};
    vecs[8] = '{1, 3'b100, 32'd6, 32'd9, 32'd0, 1'b1, 1'b1};
    order = '{0, 1, 2, 3, 0, 1};
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_id", bus.rsp_id, 0);
    chk("reset_rsp_result", bus.rsp_result, 0);
    chk("reset_rsp_flags", {bus.rsp_zero, bus.rsp_err}, 0);
    chk("reset_alu_a", bus.alu_a, 0);
    reset = 1'b0;
    foreach (vecs[i]) begin
      set_ops(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      bus.req_valid[vecs[i].id] = 1'b1;
      #1;
      chk("vec_accept_ready", bus.req_ready, 64'd1 << vecs[i].id);
      chk("vec_accept_busy", bus.busy, 0);
      tick();
      bus.req_valid = '0;
      #1;
      chk("vec_exec_busy", bus.busy, 1);
      chk("vec_exec_rsp_valid", bus.rsp_valid, 0);
      chk("vec_exec_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {vecs[i].op, vecs[i].a, vecs[i].b});
      tick();
      chk("vec_rsp_valid", bus.rsp_valid, 1);
      chk("vec_rsp_id", bus.rsp_id, vecs[i].id);
      chk("vec_rsp_result", bus.rsp_result, vecs[i].res);
      chk("vec_rsp_zero_err", {bus.rsp_zero, bus.rsp_err}, {vecs[i].z, vecs[i].e});
      tick();
      chk("vec_idle_busy", bus.busy, 0);
      chk("vec_idle_rsp_valid", bus.rsp_valid, 0);
    end
    bus.rsp_ready = 1'b0;
    set_ops(3, 3'b010, 32'd100, 32'd23);
    bus.req_valid[3] = 1'b1;
    #1;
    chk("bp_accept_ready", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    tick();
    set_ops(1, 3'b001, 32'd1, 32'd2);
    bus.req_valid[1] = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_hold", {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err}, {2'd3, 32'd123, 1'b0, 1'b0});
      chk("bp_busy", bus.busy, 1);
      chk("bp_no_ready", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    #1;
    chk("bp_handshake_no_ready", bus.req_ready, 0);
    tick();
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_idle_rsp_valid", bus.rsp_valid, 0);
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, 3'b010, 32'(10 * i), 32'd1);
    bus.req_valid = '1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    last = 0;
    for (int k = 0; k < 6; k++) begin
      cnt = 0;
      while (bus.req_ready == '0 && cnt < 8) begin
        tick();
        #1;
        cnt++;
      end
      chk("rr_grant", bus.req_ready, 64'd1 << order[k]);
      if (k > 0) chk("rr_gap", cyc - last, 3);
      last = cyc;
      tick();
      tick();
      chk("rr_rsp_id", bus.rsp_id, order[k]);
      chk("rr_rsp_result", bus.rsp_result, 10 * order[k] + 1);
      if (k == 5) bus.req_valid = '0;
      tick();
      #1;
    end
    chk("rr_end_idle", bus.busy, 0);
    set_ops(1, 3'b010, 32'd2, 32'd2);
    bus.req_valid[1] = 1'b1;
    #1;
    chk("rst_exec_accept", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    reset = 1'b1;
    #1;
    chk("rst_exec_busy", bus.busy, 1);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_after_rsp_valid", bus.rsp_valid, 0);
    chk("rst_after_busy", bus.busy, 0);
    chk("rst_after_rsp_result", bus.rsp_result, 0);
    bus.req_valid = '1;
    #1;
    chk("rst_next_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    chk("rst_rsp_valid", bus.rsp_valid, 1);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_result", bus.rsp_result, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pend = '0;
    mptr = 0;
    for (int c = 0; c < 1700; c++) begin
      bus.req_valid = pend;
      for (int i = 0; i < N; i++) begin
        if (c < 1500 && !pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          ra = $urandom;
          set_ops(i, 3'($urandom_range(0, 7)), ra, $urandom_range(0, 3) == 0 ? ra : $urandom);
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.rsp_ready = c >= 1500 || $urandom_range(0, 2) != 0;
      #1;
      g = q.size() == 0 ? rr_pick(pend, mptr) : -1;
      exp_ready = g < 0 ? '0 : N'(1) << g;
      chk("rand_ready", bus.req_ready, exp_ready);
      if (bus.rsp_valid) begin
        if (q.size() == 0) chk("rand_spurious_rsp", 1, 0);
        else begin
          if (cyc - q[0].gcyc < 3) chk("rand_latency", cyc - q[0].gcyc, 2);
          chk("rand_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err},
              {2'(q[0].id), q[0].r, q[0].z, q[0].e});
          if (bus.rsp_ready) void'(q.pop_front());
        end
      end else if (q.size() != 0 && cyc - q[0].gcyc >= 2) chk("rand_rsp_missing", 0, 1);
      if (g >= 0) begin
        rv = ref_op(bus.req_op[g*3 +: 3], bus.req_a[g*W +: W], bus.req_b[g*W +: W]);
        e = '{g, rv[31:0], rv[32], rv[33], cyc};
        q.push_back(e);
        pend[g] = 1'b0;
        mptr = (g + 1) % N;
      end
      tick();
    end
    chk("rand_drained", {q.size(), 28'd0, pend}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 32-bit combinational ALU (ops AND/OR/ADD/SUB/SLT, zero flag) between N requesters. Requesters use a valid/ready request handshake. A fair round-robin grant selects one request at a time. The selected operands are registered and driven to the external ALU. The result is captured and returned on one shared response port tagged with the requester id. Sits between the issue logic of several datapath clients and the single ALU instance.

Parameters:
W, 32, operand/result width
N, 4, number of requesters
IDW, 2, requester id width (must equal clog2(N))

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  N  per-requester request valid
req_ready  out  N  per-requester accept strobe; one-hot or zero
req_a  in  N*W  flattened operand a; requester i at [i*W +: W]
req_b  in  N*W  flattened operand b
req_op  in  N*3  flattened opcode; requester i at [i*3 +: 3]
alu_a  out  W  operand a to ALU
alu_b  out  W  operand b to ALU
alu_op  out  3  opcode to ALU
alu_result  in  W  ALU result (combinational from alu_a/alu_b/alu_op)
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  id of the requester the response belongs to
rsp_result  out  W  captured result
rsp_zero  out  1  captured zero flag
rsp_err  out  1  opcode was illegal
busy  out  1  high whenever state != IDLE

Behaviour:
- Legal opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. All other opcodes are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, grant the first set bit at or after the pointer ptr, wrapping N-1 -> 0.
  - req_ready[g] = 1 combinationally in this cycle; all other bits 0.
  - Latch req_a[g], req_b[g], req_op[g] and g into operand registers.
  - ptr <= (g+1) mod N.
  - Next state EXEC.
  - req_ready is 0 in every other state and whenever no request is valid.
- EXEC (one cycle):
  - alu_a/alu_b/alu_op are driven from the operand registers.
  - Capture rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_err <= 0, rsp_id <= g.
  - If the latched op is illegal: rsp_result <= 0, rsp_zero <= 1, rsp_err <= 1.
  - Next state RESP.
- RESP:
  - rsp_valid = 1; rsp_* outputs stay stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE.
  - No new grant is made in the handshake cycle. Minimum issue interval is 3 cycles. Latency from accept to first rsp_valid is 2 cycles.
- alu_a/alu_b/alu_op always reflect the operand registers, so they are stable outside EXEC.
- A requester that drops req_valid before grant is not served. A requester must hold its request until it sees req_ready.
- Simultaneous requests: exactly one is granted, in round-robin order. A continuously requesting client waits at most N-1 grants.
- Reset (any state, including mid-EXEC/RESP) takes effect at the next clk edge:
  - state IDLE, ptr 0, operand registers 0.
  - rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_err 0, req_ready 0, busy 0.
  - An in-flight operation is discarded with no response.

Test Plan:
- Requester 1 issues ADD a=5 b=3 alone, rsp_ready=1 -> req_ready=4'b0010 in the accept cycle; 2 cycles later rsp_valid=1, rsp_id=1, rsp_result=8, rsp_zero=0, rsp_err=0.
- Requester 0 issues SUB 7,7, then SLT 3,9, then AND 12,10, then OR 12,3 -> results 0 (zero=1), 1, 8, 15 in that order.
- All four requesters hold req_valid from reset -> grant order 0,1,2,3,0,1; each rsp_id matches its requester; grants are spaced 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_* stay constant, busy=1, no req_ready pulses; rsp_ready=1 -> IDLE next cycle.
- Illegal opcode 011 with a=1 b=1 -> rsp_err=1, rsp_result=0, rsp_zero=1.
- Assert reset during EXEC of ADD 2,2 -> the next cycle shows rsp_valid=0 and busy=0, no response is ever produced, and the next grant goes to requester 0 first.
